// File: rtl/cbf_pkg.sv
// Shared definitions for the CBF query and insert paths.
// Holds state codes, default bus widths and the k-mer chunking helper.
package cbf_pkg;

   localparam int CBF_KMER_WIDTH    = 45;
   localparam int CBF_ADDR_WIDTH    = 20;
   localparam int CBF_COUNTER_WIDTH = 4;

   typedef logic [1:0] cbf_state_t;

   localparam cbf_state_t ST_IDLE    = 2'd0;
   localparam cbf_state_t ST_ISSUE   = 2'd1;
   localparam cbf_state_t ST_WAIT    = 2'd2;
   localparam cbf_state_t ST_RESPOND = 2'd3;

   // Number of ADDR_WIDTH-bit chunks needed to cover a 2*KMER_WIDTH-bit k-mer.
   function automatic int cbf_num_chunks(input int kmer_width, input int addr_width);
      return (2 * kmer_width + addr_width - 1) / addr_width;
   endfunction

endpackage

// File: rtl/cbf_query_responder_if.sv
// Query bus from the arbitrator plus the counter-memory read port.
// The responder uses the slave view; the arbitrator/memory side uses master.
interface cbf_query_responder_if
   import cbf_pkg::*;
#(
   parameter int KMER_WIDTH    = CBF_KMER_WIDTH,
   parameter int ADDR_WIDTH    = CBF_ADDR_WIDTH,
   parameter int COUNTER_WIDTH = CBF_COUNTER_WIDTH
) ();

   logic [2*KMER_WIDTH-1:0]  kmerToCBF;
   logic                     kmerValidToCBF;
   logic                     cbfReady;
   logic                     kmerPositive;
   logic                     resultValid;
   logic [ADDR_WIDTH-1:0]    memAddr;
   logic                     memRead;
   logic [COUNTER_WIDTH-1:0] memReadData;
   logic                     memReadValid;

   modport slave (
      input  kmerToCBF,
      input  kmerValidToCBF,
      output cbfReady,
      output kmerPositive,
      output resultValid,
      output memAddr,
      output memRead,
      input  memReadData,
      input  memReadValid
   );

   modport master (
      output kmerToCBF,
      output kmerValidToCBF,
      input  cbfReady,
      input  kmerPositive,
      input  resultValid,
      input  memAddr,
      input  memRead,
      output memReadData,
      output memReadValid
   );

endinterface

// File: rtl/cbf_hash_fold.sv
// Folds a k-mer into the two double-hashing seeds h1/h2 (purely combinational).
// Shared by the query responder and the insert path.
module cbf_hash_fold
   import cbf_pkg::*;
#(
   parameter int KMER_WIDTH = CBF_KMER_WIDTH,
   parameter int ADDR_WIDTH = CBF_ADDR_WIDTH
) (
   input  logic [2*KMER_WIDTH-1:0] kmer_i,
   output logic [ADDR_WIDTH-1:0]   h1_o,
   output logic [ADDR_WIDTH-1:0]   h2_o
);

   localparam int KB  = 2 * KMER_WIDTH;
   localparam int NCH = cbf_num_chunks(KMER_WIDTH, ADDR_WIDTH);
   localparam int PW  = NCH * ADDR_WIDTH;

   logic [PW-1:0] fwd;
   logic [PW-1:0] rev;

   always_comb begin
      fwd = '0;
      rev = '0;
      fwd[KB-1:0] = kmer_i;
      for (int b = 0; b < KB; b++) begin
         rev[b] = kmer_i[KB-1-b];
      end
      h1_o = '0;
      h2_o = '0;
      for (int c = 0; c < NCH; c++) begin
         h1_o = h1_o ^ fwd[c*ADDR_WIDTH +: ADDR_WIDTH];
         h2_o = h2_o ^ rev[c*ADDR_WIDTH +: ADDR_WIDTH];
      end
      // An odd stride keeps successive probe addresses distinct.
      h2_o[0] = 1'b1;
   end

endmodule

// File: rtl/cbf_query_responder.sv
// CBF query responder: hashes one k-mer, reads NUM_HASHES counters and
// reports whether all of them reach THRESHOLD, one query in flight at a time.
module cbf_query_responder
   import cbf_pkg::*;
#(
   parameter int KMER_WIDTH     = CBF_KMER_WIDTH,
   parameter int ADDR_WIDTH     = CBF_ADDR_WIDTH,
   parameter int COUNTER_WIDTH  = CBF_COUNTER_WIDTH,
   parameter int NUM_HASHES     = 4,
   parameter int THRESHOLD      = 1,
   parameter int HASH_CNT_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rstb,
   cbf_query_responder_if.slave  bus
);

   localparam logic [HASH_CNT_WIDTH-1:0] LAST_ISSUE   = HASH_CNT_WIDTH'(NUM_HASHES - 1);
   localparam logic [HASH_CNT_WIDTH-1:0] ALL_RETURNED = HASH_CNT_WIDTH'(NUM_HASHES);
   localparam logic [COUNTER_WIDTH-1:0]  THRESH       = COUNTER_WIDTH'(THRESHOLD);

   cbf_state_t                state_q, state_d;
   logic                      alive_q;
   logic [ADDR_WIDTH-1:0]     h2_q, h2_d;
   logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
   logic [HASH_CNT_WIDTH-1:0] iss_cnt_q, iss_cnt_d;
   logic [HASH_CNT_WIDTH-1:0] ret_cnt_q, ret_cnt_d;
   logic                      hit_q, hit_d;
   logic                      result_vld_q, result_vld_d;
   logic                      positive_q, positive_d;

   logic [ADDR_WIDTH-1:0]     fold_h1;
   logic [ADDR_WIDTH-1:0]     fold_h2;
   logic                      accept;
   logic                      ret_take;

   cbf_hash_fold #(
      .KMER_WIDTH (KMER_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_fold (
      .kmer_i (bus.kmerToCBF),
      .h1_o   (fold_h1),
      .h2_o   (fold_h2)
   );

   // Ready comes only from registered state so the arbitrator can gate valid with it.
   assign bus.cbfReady     = alive_q && (state_q == ST_IDLE);
   assign bus.memRead      = (state_q == ST_ISSUE);
   assign bus.memAddr      = addr_q;
   assign bus.resultValid  = result_vld_q;
   assign bus.kmerPositive = positive_q;

   always_comb begin
      accept   = bus.cbfReady && bus.kmerValidToCBF;
      ret_take = bus.memReadValid && ((state_q == ST_ISSUE) || (state_q == ST_WAIT));

      state_d      = state_q;
      h2_d         = h2_q;
      addr_d       = addr_q;
      iss_cnt_d    = iss_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      hit_d        = hit_q;
      result_vld_d = 1'b0;
      positive_d   = positive_q;

      // Returns outside ISSUE/WAIT are strays and never touch the query state.
      if (ret_take) begin
         ret_cnt_d = ret_cnt_q + 1'b1;
         hit_d     = hit_q & (bus.memReadData >= THRESH);
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               h2_d      = fold_h2;
               addr_d    = fold_h1;
               iss_cnt_d = '0;
               ret_cnt_d = '0;
               hit_d     = 1'b1;
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            addr_d    = addr_q + h2_q;
            iss_cnt_d = iss_cnt_q + 1'b1;
            if (iss_cnt_q == LAST_ISSUE) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Looking at the next count lets the final return go straight to RESPOND.
            if (ret_cnt_d == ALL_RETURNED) begin
               state_d      = ST_RESPOND;
               result_vld_d = 1'b1;
               positive_d   = hit_d;
            end
         end
         ST_RESPOND: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q      <= ST_IDLE;
         alive_q      <= 1'b0;
         h2_q         <= '0;
         addr_q       <= '0;
         iss_cnt_q    <= '0;
         ret_cnt_q    <= '0;
         hit_q        <= 1'b0;
         result_vld_q <= 1'b0;
         positive_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         alive_q      <= 1'b1;
         h2_q         <= h2_d;
         addr_q       <= addr_d;
         iss_cnt_q    <= iss_cnt_d;
         ret_cnt_q    <= ret_cnt_d;
         hit_q        <= hit_d;
         result_vld_q <= result_vld_d;
         positive_q   <= positive_d;
      end
   end

endmodule

// File: tb/tb_cbf_query_responder.sv
// Scoreboard bench for cbf_query_responder: three instances (1, 3 and 15 hashes)
// run randomized queries against a behavioural hash/threshold model and a latency memory.
module tb_cbf_query_responder;

   localparam int KW      = 4;
   localparam int AW      = 4;
   localparam int CW      = 4;
   localparam int NQ      = 12;
   localparam int ABORT_Q = 6;

   typedef struct {
      bit     pos;
      longint due;
   } exp_t;

   typedef struct {
      longint due;
      int     data;
   } ret_t;

   logic   clk = 1'b0;
   longint cyc = 0;
   int     checks = 0;
   int     failures = 0;
   int     done_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input int inst, input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL inst%0d %s actual=%0d required=%0d at cycle %0d", inst, name, act, req, cyc);
      end
   endtask

   // XOR of the AW-bit chunks of a k-mer, LSB chunk first, top chunk zero-padded.
   function automatic int fold(input logic [2*KW-1:0] k);
      int v;
      v = 0;
      for (int c = 0; c < (2*KW + AW - 1) / AW; c++) begin
         v = v ^ ((int'(k) >> (c * AW)) & ((1 << AW) - 1));
      end
      return v;
   endfunction

   function automatic logic [2*KW-1:0] bitrev(input logic [2*KW-1:0] k);
      logic [2*KW-1:0] r;
      for (int i = 0; i < 2*KW; i++) r[i] = k[2*KW-1-i];
      return r;
   endfunction

   function automatic int ref_addr(input logic [2*KW-1:0] k, input int i);
      int h1;
      int h2;
      h1 = fold(k);
      h2 = fold(bitrev(k)) | 1;
      return (h1 + i * h2) % (1 << AW);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_inst
      localparam int NH = (g == 0) ? 3 : ((g == 1) ? 1 : 15);
      localparam int TH = (g == 2) ? 2 : 1;

      logic rstb;
      int   lat_cur;
      bit   force_stray;
      int   mem [1 << AW];
      int   addrq [$];
      exp_t expq [$];
      ret_t pend [$];

      cbf_query_responder_if #(
         .KMER_WIDTH    (KW),
         .ADDR_WIDTH    (AW),
         .COUNTER_WIDTH (CW)
      ) bus ();

      cbf_query_responder #(
         .KMER_WIDTH     (KW),
         .ADDR_WIDTH     (AW),
         .COUNTER_WIDTH  (CW),
         .NUM_HASHES     (NH),
         .THRESHOLD      (TH),
         .HASH_CNT_WIDTH (4)
      ) u_dut (
         .clk  (clk),
         .rstb (rstb),
         .bus  (bus)
      );

      // Counter memory: fixed latency per query, in-order returns, optional strays while idle.
      initial begin : mem_model
         bus.memReadValid = 1'b0;
         bus.memReadData  = '0;
         forever begin
            @(negedge clk);
            bus.memReadValid = 1'b0;
            if (pend.size() > 0 && pend[0].due == cyc) begin
               bus.memReadValid = 1'b1;
               bus.memReadData  = CW'(pend[0].data);
               void'(pend.pop_front());
            end else if ((bus.cbfReady === 1'b1 || bus.resultValid === 1'b1) &&
                         (force_stray || $urandom_range(0, 3) == 0)) begin
               bus.memReadValid = 1'b1;
               bus.memReadData  = '0;
            end
            if (bus.memRead === 1'b1) begin
               chk(g, "memRead_expected", longint'(addrq.size() > 0), 1);
               if (addrq.size() > 0) chk(g, "memAddr", bus.memAddr, addrq.pop_front());
               pend.push_back('{due: cyc + lat_cur, data: mem[bus.memAddr]});
            end
         end
      end

      initial begin : monitor
         exp_t e;
         forever begin
            @(negedge clk);
            if (bus.resultValid === 1'b1) begin
               chk(g, "result_expected", longint'(expq.size() > 0), 1);
               if (expq.size() > 0) begin
                  e = expq.pop_front();
                  chk(g, "kmerPositive", bus.kmerPositive, e.pos);
                  chk(g, "result_cycle", cyc, e.due);
               end
            end
         end
      end

      initial begin : stim
         logic [2*KW-1:0] k;
         int     lat;
         int     tmo;
         int     a;
         bit     exp_pos;
         bit     allhit;
         longint acc;

         rstb               = 1'b0;
         bus.kmerToCBF      = '0;
         bus.kmerValidToCBF = 1'b0;
         lat_cur            = 1;
         force_stray        = 1'b0;
         for (int i = 0; i < (1 << AW); i++) mem[i] = 0;

         repeat (3) @(negedge clk);
         chk(g, "rst_cbfReady", bus.cbfReady, 0);
         chk(g, "rst_resultValid", bus.resultValid, 0);
         chk(g, "rst_memRead", bus.memRead, 0);
         chk(g, "rst_memAddr", bus.memAddr, 0);
         rstb = 1'b1;
         @(negedge clk);
         chk(g, "ready_after_release", bus.cbfReady, 1);

         for (int q = 0; q < NQ; q++) begin
            tmo = 0;
            while (bus.cbfReady !== 1'b1 && tmo < 400) begin
               @(negedge clk);
               tmo++;
            end
            chk(g, "ready_before_query", longint'(bus.cbfReady === 1'b1), 1);
            repeat ($urandom_range(0, 2)) @(negedge clk);

            k   = (q == 0 || q == ABORT_Q + 1) ? (2*KW)'(8'hA5) : (2*KW)'($urandom);
            lat = (q == 0) ? 2 : int'($urandom_range(1, 3));
            allhit = 1'($urandom_range(0, 1));
            for (int i = 0; i < (1 << AW); i++) begin
               mem[i] = allhit ? int'($urandom_range(TH, 15)) : int'($urandom_range(0, TH));
            end
            exp_pos = 1'b1;
            for (int i = 0; i < NH; i++) begin
               a = ref_addr(k, i);
               addrq.push_back(a);
               if (mem[a] < TH) exp_pos = 1'b0;
            end
            lat_cur = lat;
            acc     = cyc;
            if (q != ABORT_Q) expq.push_back('{pos: exp_pos, due: acc + NH + lat + 1});

            bus.kmerToCBF      = k;
            bus.kmerValidToCBF = 1'b1;
            @(negedge clk);
            bus.kmerValidToCBF = 1'b0;

            if (q == ABORT_Q) begin
               @(posedge clk);
               #1 rstb = 1'b0;
               addrq.delete();
               repeat (2) begin
                  @(negedge clk);
                  chk(g, "abort_cbfReady", bus.cbfReady, 0);
                  chk(g, "abort_memRead", bus.memRead, 0);
               end
               tmo = 0;
               while (pend.size() > 0 && tmo < 20) begin
                  @(negedge clk);
                  tmo++;
               end
               @(negedge clk);
               rstb = 1'b1;
               force_stray = 1'b1;
               repeat (2) @(negedge clk);
               force_stray = 1'b0;
            end else begin
               // Busy window: stray valids must be ignored and ready must return on time.
               tmo = 0;
               while (bus.cbfReady !== 1'b1 && tmo < 400) begin
                  if ($urandom_range(0, 3) == 0) begin
                     bus.kmerToCBF      = (2*KW)'($urandom);
                     bus.kmerValidToCBF = 1'b1;
                  end
                  @(negedge clk);
                  bus.kmerValidToCBF = 1'b0;
                  tmo++;
               end
               chk(g, "ready_return_cycle", cyc, acc + NH + lat + 2);
            end
         end

         repeat (3) @(negedge clk);
         chk(g, "results_outstanding", expq.size(), 0);
         chk(g, "addresses_outstanding", addrq.size(), 0);
         done_cnt++;
      end
   end

   initial begin : finisher
      int tmo;
      tmo = 0;
      while (done_cnt < 3 && tmo < 30000) begin
         @(negedge clk);
         tmo++;
      end
      chk(-1, "all_streams_done", done_cnt, 3);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cbf_query_responder.md
Name: cbf_query_responder

Overview:
- CBF-side responder for the k-mer query protocol driven by the multi-master arbitrator: accepts one k-mer on kmerToCBF/kmerValidToCBF, returns kmerPositive with a one-cycle resultValid, strictly in acceptance order.
- Derives NUM_HASHES counter addresses by double hashing, reads counters from an external counter memory, and declares the k-mer positive iff every counter is >= THRESHOLD.
- Sits between the arbitrator and the counter RAM. One query is in flight at a time.

Parameters:
- KMER_WIDTH, 45: bases per k-mer; the k-mer bus is 2*KMER_WIDTH bits.
- ADDR_WIDTH, 20: counter memory address width.
- COUNTER_WIDTH, 4: width of each counter.
- NUM_HASHES, 4: reads per query, range 1..15.
- THRESHOLD, 1: minimum counter value for a hit. Must fit COUNTER_WIDTH.
- HASH_CNT_WIDTH, 4: width of the issue and return counters. Must hold NUM_HASHES.

Ports:
- clk, in, 1: clock.
- rstb, in, 1: asynchronous active-low reset.
- kmerToCBF, in, 2*KMER_WIDTH: query k-mer.
- kmerValidToCBF, in, 1: query valid.
- cbfReady, out, 1: block can accept a query this cycle.
- kmerPositive, out, 1: query result, meaningful only with resultValid.
- resultValid, out, 1: single-cycle result strobe.
- memAddr, out, ADDR_WIDTH: counter read address.
- memRead, out, 1: read request, one address per cycle.
- memReadData, in, COUNTER_WIDTH: returned counter.
- memReadValid, in, 1: return strobe. Returns arrive in order, latency >= 1, with no backpressure.

Behaviour:
- Reset values: cbfReady=0 during reset and 1 in the first cycle after release. kmerPositive=0, resultValid=0, memRead=0, memAddr=0. FSM=IDLE; all counters and registers cleared.
- cbfReady is a pure function of registered state (state==IDLE). It must never depend on kmerValidToCBF, because the arbitrator gates valid with cbfReady combinationally.
- Accept: when kmerValidToCBF & cbfReady are high in IDLE, capture the k-mer and h1/h2 registers, then go to ISSUE. kmerValidToCBF outside IDLE is ignored, which is a protocol error upstream.
- Hash:
  - Split the k-mer into ceil(2*KMER_WIDTH/ADDR_WIDTH) ADDR_WIDTH-bit chunks, LSB first, zero-padding the top chunk.
  - h1 = XOR of all chunks.
  - h2 = XOR of the chunks of the bit-reversed k-mer, with bit 0 forced to 1.
  - addr_i = (h1 + i*h2) mod 2^ADDR_WIDTH for i = 0..NUM_HASHES-1. Compute it incrementally: addr_0 = h1, addr_{i+1} = addr_i + h2, wrapping silently.
- ISSUE:
  - memRead=1 with memAddr=addr_i for NUM_HASHES consecutive cycles; the issue counter increments each cycle.
  - After the last issue, go to WAIT.
- Returns are accepted in ISSUE and WAIT alike. Each memReadValid increments the return counter and ANDs (memReadData >= THRESHOLD) into a hit flag. The hit flag is set to 1 on accept.
- WAIT: when return count == NUM_HASHES, go to RESPOND.
  - A return arriving in the same cycle as the last issue is counted normally.
- RESPOND: one cycle with resultValid=1 and kmerPositive=hit flag, both registered. Go to IDLE the next cycle.
- Latency: with memory latency L, an accept in cycle 0 produces resultValid in cycle NUM_HASHES+L+1. The next accept is possible in cycle NUM_HASHES+L+2.
- memReadValid in IDLE or RESPOND is stray: it is ignored and must not affect later queries.
- Reset mid-query: the query is abandoned with no resultValid. The arbitrator shares rstb and clears its token FIFO, so ordering stays consistent.
- kmerPositive holds its last value between strobes; the bench checks it only under resultValid.

Decomposition:
- Shared package cbf_pkg holds:
  - FSM state encoding (IDLE, ISSUE, WAIT, RESPOND);
  - the chunk-count constant function ceil(2*KMER_WIDTH/ADDR_WIDTH);
  - the default KMER_WIDTH, ADDR_WIDTH and COUNTER_WIDTH shared with the arbitrator.
- One natural sub-module, cbf_hash_fold: combinational folding of k-mer → h1/h2, parameterised on KMER_WIDTH and ADDR_WIDTH. It is reused by the CBF insert path.

Test Plan:
- Hash example (KMER_WIDTH=4, ADDR_WIDTH=4, NUM_HASHES=3, memory latency 2):
  - Stimulus: accept kmer 8'hA5.
  - Required: h1=4'hF, h2=4'hF, memAddr sequence F, E, D on three consecutive memRead cycles; resultValid 6 cycles after accept.
- All hit: same setup, memory returns 1, 3, 1 with THRESHOLD=1 → resultValid pulse of 1 cycle with kmerPositive=1.
- One miss: returns 2, 0, 5 → kmerPositive=0. cbfReady=0 from the cycle after accept through RESPOND, then 1.
- Back-to-back via the arbitrator (2 masters, both valid continuously):
  - Each query produces exactly one resultValid.
  - The arbitrator routes alternating results to master 1 while it holds priority; no result is lost.
  - No kmerValidToCBF is seen while cbfReady=0.
- Stray and reset: assert rstb=0 mid-ISSUE.
  - No resultValid is produced.
  - A stray memReadValid in IDLE after reset is ignored.
  - The next query (kmer 8'hA5) gives the correct result.
- Wrap and limits: h1=4'hF, h2=4'h3, NUM_HASHES=1 with latency 1.
  - Single address F; resultValid 3 cycles after accept.
  - Repeat with NUM_HASHES=15; addresses wrap mod 16.
